irq_priority_controller: RTL

- Sequential front end for the generic priority encoder. It captures edge-triggered requests on N lines into sticky pending bits, applies a mask, and selects the highest-index pending line.
- Presents the selected line number on a valid/ack handshake and holds it stable until the consumer acknowledges.
- Sits between raw request sources and the consumer of the encoded index.

---
 rtl/irq_priority_controller.sv | 125 ++++++++++++
 1 files changed

// File: rtl/irq_priority_controller.sv
// Edge-captured interrupt front end: sticky pending bits, mask, highest-index
// selection and a valid/ack presentation handshake with a saturating drop counter.
module irq_priority_controller #(
  parameter int unsigned N     = 4,
  parameter int unsigned ID_W  = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic             mask_we,
  input  logic [N-1:0]     mask_in,
  input  logic             irq_ack,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  output logic [N-1:0]     pending,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned PopW = $clog2(N + 1);
  localparam int unsigned SumW = CNT_W + PopW;
  localparam logic [SumW-1:0] MaxCnt = {{PopW{1'b0}}, {CNT_W{1'b1}}};

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     req_q;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     mask_q, mask_d;
  logic             valid_q, valid_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [N-1:0]     evt;
  logic [N-1:0]     clr;
  logic [N-1:0]     drop_ev;
  logic [N-1:0]     cand;
  logic [PopW-1:0]  pop;
  logic [SumW-1:0]  sum;
  logic [ID_W-1:0]  winner;
  logic             any;

  // Capture, pending update and drop accounting.
  always_comb begin
    evt = req & ~req_q;
    clr = '0;
    if (state_q == StPresent && irq_ack) begin
      clr[id_q] = 1'b1;
    end
    // A new event on a line being cleared wins and is not a drop.
    pending_d = (pending_q & ~clr) | evt;
    drop_ev   = evt & pending_q & ~clr;
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + PopW'(drop_ev[i]);
    end
    sum    = {{PopW{1'b0}}, drop_q} + {{CNT_W{1'b0}}, pop};
    drop_d = (sum > MaxCnt) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    mask_d = mask_we ? mask_in : mask_q;
  end

  // Highest set index of the unmasked pending lines wins.
  always_comb begin
    cand   = pending_q & mask_q;
    any    = |cand;
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) begin
        winner = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    id_d    = id_q;
    unique case (state_q)
      StIdle: begin
        if (en && any) begin
          id_d    = winner;
          valid_d = 1'b1;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (irq_ack) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      req_q     <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      valid_q   <= 1'b0;
      id_q      <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      drop_q    <= drop_d;
    end
  end

  assign irq_valid = valid_q;
  assign irq_id    = id_q;
  assign pending   = pending_q;
  assign drop_cnt  = drop_q;

endmodule
